bitwise_frame_accumulator: RTL and testbench
============================================

// Module: bitwise_frame_accumulator
// PURPOSE
//  Downstream consumer of the 16-bit bitwise gate stage: accepts a frame of W-bit words over a
//  valid/ready stream and folds them into one accumulator with OR, AND or XOR.
//  Emits the folded word plus beat count over a second valid/ready stream.
//  Used for lab datapaths that reduce gate-array outputs, e.g. collecting flags across many cycles.
// PARAMETERS
//  W          16   data width of input words and accumulator
//  MAX_BEATS  8    beats that force frame end when in_last is absent; legal range 1..255
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        input word present
//  in_ready   out  1        block can take an input word
//  in_data    in   W        input word
//  in_last    in   1        word is last of frame; qualified by in_valid
//  in_op      in   2        fold op: 00 OR, 01 AND, 10 XOR, 11 treated as OR; sampled on first beat only
//  out_valid  out  1        result present
//  out_ready  in   1        downstream takes result
//  out_data   out  W        folded result
//  out_count  out  CW       beats in frame, CW = $clog2(MAX_BEATS+1)
//  out_parity out  1        only with BITACC_PARITY_EN: XOR-reduce of out_data
// BEHAVIOUR
//  - Reset: FSM=IDLE, acc=0, count=0, op=OR; out_valid=0, out_data=0, out_count=0, in_ready=1.
//  - Input beat = in_valid & in_ready. Output beat = out_valid & out_ready.
//  - States:
//    IDLE: in_ready=1. A beat loads acc=in_data, count=1, latches in_op.
//          If in_last, or MAX_BEATS==1, go to DONE. Otherwise go to ACCUM.
//    ACCUM: in_ready=1. A beat sets acc = acc <op> in_data and count += 1.
//          Go to DONE if in_last or count+1 == MAX_BEATS; otherwise stay in ACCUM.
//    DONE: in_ready=0, out_valid=1, out_data=acc, out_count=count; all three stay stable until the output beat.
//          Output beat returns to IDLE. acc and count are not cleared; the next first beat overwrites them.
//  - Latency: out_valid rises on the cycle after the final input beat is accepted.
//  - DONE always costs one bubble: in_ready stays 0 in the output-beat cycle and is 1 on the next cycle.
//  - in_op changes in the middle of a frame are ignored. The op latched on the first beat applies to the whole frame.
//  - in_last in the same beat that reaches MAX_BEATS: one frame end, no double count.
//  - in_valid=0 in ACCUM: hold acc and count indefinitely; there is no timeout.
//  - Reset asserted mid-frame or in DONE: frame is discarded and all state returns to reset values immediately.
//  - All outputs are registered or decoded only from FSM state; there are no combinational in->out paths.
// CONFIGURATION
//  BITACC_PARITY_EN defined: out_parity port exists. It is registered and updates on the same clock
//  edge as out_data (value = ^acc on entry to DONE). It resets to 0.
//  BITACC_PARITY_EN undefined: out_parity port and its flop are absent. All other behaviour is identical.
// STRUCTURE
//  - bitacc_pkg holds:
//    typedef enum logic[1:0] {OP_OR, OP_AND, OP_XOR, OP_RSVD} bitacc_op_e;
//    typedef enum logic[1:0] {S_IDLE, S_ACCUM, S_DONE} bitacc_state_e.
//  - Sub-module bitacc_op_unit: combinational W-bit fold (a, b, op -> y).
//    Per-bit OR/AND/XOR plus op mux; OP_RSVD maps to OR.
//  - Top level holds the FSM, accumulator, counter and output registers.
// TESTING
//  1 Reset mid-ACCUM after 3 beats -> out_valid=0, in_ready=1. Next frame 0x0001(last) -> out_data=0x0001, count=1.
//  2 OR frame 0x0001,0x0010,0x0100,0x1000(last) -> out_data=0x1111, count=4, out_valid 1 cycle after last beat.
//  3 AND frame 0xFFFF,0x0F0F,0x00FF(last); in_op set to 01 on first beat, then toggled to 10 on beats 2-3
//    -> out_data=0x000F, count=3 (later op changes ignored).
//  4 XOR frame with no in_last, 8 beats of 0xAAAA -> forced end at MAX_BEATS: out_data=0x0000, count=8.
//    With BITACC_PARITY_EN: out_parity=0. A 7-beat frame of 0xAAAA with in_last -> out_data=0xAAAA, parity=0.
//  5 Backpressure: out_ready=0 for 5 cycles in DONE -> out_data/out_count stable, in_ready=0 throughout;
//    raise out_ready -> IDLE next cycle.
//  6 Gapped input: in_valid low 4 cycles between beats of OR frame 0x8000,0x0001(last)
//    -> out_data=0x8001, count=2; in_op=11 on first beat gives the same result.

Source files
------------

// File: rtl/bitacc_pkg.sv
// Shared types for the bitwise frame accumulator.
// Fold operation and FSM state encodings.
package bitacc_pkg;

  typedef enum logic [1:0] {
    OP_OR,
    OP_AND,
    OP_XOR,
    OP_RSVD
  } bitacc_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } bitacc_state_e;

endpackage

// File: rtl/bitacc_op_unit.sv
// Combinational W-bit fold: y_o = a_i <op_i> b_i.
// Ports: a_i, b_i operands; op_i fold op (OP_RSVD acts as OR); y_o result.
module bitacc_op_unit
  import bitacc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  bitacc_op_e   op_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = a_i | b_i;
    unique case (op_i)
      OP_OR,
      OP_RSVD: y_o = a_i | b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
    endcase
  end

endmodule

// File: rtl/bitwise_frame_accumulator.sv
// Folds a frame of W-bit words (OR/AND/XOR) and emits result + beat count.
// Ports: clk, rst (async high); in_valid/in_ready/in_data/in_last/in_op
//   input stream; out_valid/out_ready/out_data/out_count output stream;
//   out_parity (only when BITACC_PARITY_EN is defined) = ^out_data.
module bitwise_frame_accumulator
  import bitacc_pkg::*;
#(
  parameter  int W         = 16,
  parameter  int MAX_BEATS = 8,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  input  logic [1:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_count
`ifdef BITACC_PARITY_EN
  ,
  output logic          out_parity
`endif
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_BEATS);

  bitacc_state_e state_q;
  bitacc_op_e    op_q;
  logic [W-1:0]  acc_q;
  logic [CW-1:0] count_q;
  logic [W-1:0]  out_data_q;
  logic [CW-1:0] out_count_q;
  logic [W-1:0]  fold_y;
  logic [CW-1:0] count_inc;

  assign count_inc = count_q + CW'(1);

  bitacc_op_unit #(.W(W)) u_op (
    .a_i (acc_q),
    .b_i (in_data),
    .op_i(op_q),
    .y_o (fold_y)
  );

  // Handshake outputs decode straight from state; no in->out comb path.
  assign in_ready  = (state_q != S_DONE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

`ifdef BITACC_PARITY_EN
  logic parity_q;
  assign out_parity = parity_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_OR;
      acc_q       <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
`ifdef BITACC_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            acc_q   <= in_data;
            count_q <= CW'(1);
            op_q    <= bitacc_op_e'(in_op);
            if (in_last || MAX_BEATS == 1) begin
              state_q     <= S_DONE;
              out_data_q  <= in_data;
              out_count_q <= CW'(1);
`ifdef BITACC_PARITY_EN
              parity_q    <= ^in_data;
`endif
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc_q   <= fold_y;
            count_q <= count_inc;
            // in_last on the MAX_BEATS beat is one frame end
            if (in_last || count_inc == MAX_C) begin
              state_q     <= S_DONE;
              out_data_q  <= fold_y;
              out_count_q <= count_inc;
`ifdef BITACC_PARITY_EN
              parity_q    <= ^fold_y;
`endif
            end
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_frame_accumulator.sv
// Directed self-checking bench for bitwise_frame_accumulator.
// Builds with or without BITACC_PARITY_EN.
module tb_bitwise_frame_accumulator;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
`ifdef BITACC_PARITY_EN
  logic          out_parity;
`endif

  int checks   = 0;
  int failures = 0;

  bitwise_frame_accumulator #(.W(W), .MAX_BEATS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
`ifdef BITACC_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic l,
                      input logic [1:0] op);
    chk("in_ready_pre_beat", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_op    = op;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic result(input string tag, input logic [W-1:0] d,
                        input logic [CW-1:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    chk({tag, "_ready_lo"}, 32'(in_ready), 32'd0);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_op     = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
`ifdef BITACC_PARITY_EN
    chk("rst_parity", 32'(out_parity), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // 1: reset mid-ACCUM
    beat(16'h1234, 1'b0, 2'b10);
    beat(16'h00F0, 1'b0, 2'b10);
    beat(16'h0F00, 1'b0, 2'b10);
    rst = 1'b1;
    #1;
    chk("t1_rst_valid", 32'(out_valid), 32'd0);
    chk("t1_rst_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    beat(16'h0001, 1'b1, 2'b00);
    result("t1", 16'h0001, 4'd1);
`ifdef BITACC_PARITY_EN
    chk("t1_parity", 32'(out_parity), 32'd1);
`endif
    drain("t1");

    // 2: OR frame, latency check
    beat(16'h0001, 1'b0, 2'b00);
    beat(16'h0010, 1'b0, 2'b00);
    beat(16'h0100, 1'b0, 2'b00);
    chk("t2_not_yet_valid", 32'(out_valid), 32'd0);
    beat(16'h1000, 1'b1, 2'b00);
    result("t2", 16'h1111, 4'd4);

    // 5: backpressure on the t2 result, offered input ignored
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      result("t5_hold", 16'h1111, 4'd4);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain("t5");

    // 3: AND frame, later op changes ignored
    beat(16'hFFFF, 1'b0, 2'b01);
    beat(16'h0F0F, 1'b0, 2'b10);
    beat(16'h00FF, 1'b1, 2'b10);
    result("t3", 16'h000F, 4'd3);
    drain("t3");

    // 4a: XOR 8 beats, no last -> forced end
    for (int i = 0; i < 7; i++) beat(16'hAAAA, 1'b0, 2'b10);
    chk("t4a_not_yet_valid", 32'(out_valid), 32'd0);
    beat(16'hAAAA, 1'b0, 2'b10);
    result("t4a", 16'h0000, 4'd8);
`ifdef BITACC_PARITY_EN
    chk("t4a_parity", 32'(out_parity), 32'd0);
`endif
    drain("t4a");

    // 4b: 7-beat XOR frame with last
    for (int i = 0; i < 6; i++) beat(16'hAAAA, 1'b0, 2'b10);
    beat(16'hAAAA, 1'b1, 2'b10);
    result("t4b", 16'hAAAA, 4'd7);
`ifdef BITACC_PARITY_EN
    chk("t4b_parity", 32'(out_parity), 32'd0);
`endif
    drain("t4b");

    // 4c: last coinciding with MAX_BEATS -> single frame
    for (int i = 0; i < 7; i++) beat(16'h0001 << i, 1'b0, 2'b00);
    beat(16'h8000, 1'b1, 2'b00);
    result("t4c", 16'h807F, 4'd8);
    drain("t4c");
    tick();
    chk("t4c_no_second_frame", 32'(out_valid), 32'd0);

    // 6: gapped OR frame
    beat(16'h8000, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_gap_valid", 32'(out_valid), 32'd0);
    beat(16'h0001, 1'b1, 2'b00);
    result("t6", 16'h8001, 4'd2);
    drain("t6");

    // 6b: same with op=11
    beat(16'h8000, 1'b0, 2'b11);
    for (int i = 0; i < 4; i++) tick();
    beat(16'h0001, 1'b1, 2'b11);
    result("t6b", 16'h8001, 4'd2);
    drain("t6b");

    // op=11 must be OR, not XOR
    beat(16'h00FF, 1'b0, 2'b11);
    beat(16'h0F0F, 1'b1, 2'b11);
    result("t6c", 16'h0FFF, 4'd2);
`ifdef BITACC_PARITY_EN
    chk("t6c_parity", 32'(out_parity), 32'd0);
`endif
    drain("t6c");

    // reset while in DONE
    beat(16'h0055, 1'b1, 2'b00);
    result("t7", 16'h0055, 4'd1);
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", 32'(out_valid), 32'd0);
    chk("t7_rst_data", 32'(out_data), 32'd0);
    chk("t7_rst_count", 32'(out_count), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
